// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg
// Types and default constants shared by the USB receive datapath blocks.
//   rx_state_t          : deserializer state (RUN = framing words, ERR = stuffing violation)
//   DEFAULT_DATA_WIDTH  : default bits per assembled word
//   DEFAULT_STUFF_LEN   : default run of ones after which a stuffed bit follows
package usb_rx_pkg;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } rx_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_STUFF_LEN  = 6;

endpackage

// File: rtl/flex_stp_sr.sv
// flex_stp_sr
// Flexible serial-to-parallel shift register.
//   clk          : rising-edge clock
//   n_rst        : asynchronous active-low reset, loads all ones (line idle level)
//   shift_enable : shift one bit in this cycle
//   serial_in    : bit entering the register
//   parallel_out : current register contents
// SHIFT_MSB=1 shifts toward the MSB with new bits entering at bit 0;
// SHIFT_MSB=0 shifts toward the LSB with new bits entering at the MSB.
module flex_stp_sr #(
  parameter int NUM_BITS  = 4,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parallel_out <= '1;
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in};
      end else begin
        parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/rx_deserializer.sv
// rx_deserializer
// Assembles NRZI-decoded serial bits into words, removing stuffed bits and
// flagging stuffing violations.
//   clk          : rising-edge clock
//   n_rst        : asynchronous active-low reset
//   shift_enable : one-cycle strobe marking a valid bit on d_orig
//   d_orig       : decoded serial bit
//   clear        : synchronous restart of word framing (SYNC / EOP)
//   rcv_data     : last complete word, held until the next one
//   byte_ready   : one-cycle pulse when rcv_data updates
//   stuff_err    : stuffing violation seen, held until clear
//   partial      : an incomplete word is being held
module rx_deserializer
  import usb_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int STUFF_LEN  = DEFAULT_STUFF_LEN
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  shift_enable,
  input  logic                  d_orig,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] rcv_data,
  output logic                  byte_ready,
  output logic                  stuff_err,
  output logic                  partial
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

  rx_state_t state, next_state;

  logic [BW-1:0]         bit_cnt;
  logic [OW-1:0]         ones_cnt;
  logic                  word_done;
  logic                  shift_bit;
  logic                  stuffed_bit;
  logic [DATA_WIDTH-1:0] sr_word;

  // The shift register only sees bits that are real data: stuffed bits,
  // bits arriving in ERR, and bits coinciding with clear never reach it.
  flex_stp_sr #(
    .NUM_BITS  (DATA_WIDTH),
    .SHIFT_MSB (!LSB_FIRST)
  ) u_shift (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_bit),
    .serial_in    (d_orig),
    .parallel_out (sr_word)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // A bit following a full run of ones is the stuffed bit; it must be 0,
  // otherwise the stream is corrupt and we park in ERR until clear.
  always_comb begin
    next_state  = state;
    shift_bit   = 1'b0;
    stuffed_bit = 1'b0;
    if (clear) begin
      next_state = RUN;
    end else if (state == RUN && shift_enable) begin
      if (ones_cnt == ONES_MAX) begin
        stuffed_bit = 1'b1;
        if (d_orig) begin
          next_state = ERR;
        end
      end else begin
        shift_bit = 1'b1;
      end
    end
  end

  // The ones run deliberately carries across word boundaries, since
  // stuffing is a property of the bit stream rather than of the words.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      word_done <= 1'b0;
    end else if (clear) begin
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (stuffed_bit) begin
        ones_cnt <= '0;
      end else if (shift_bit) begin
        ones_cnt <= d_orig ? ones_cnt + OW'(1) : '0;
        if (bit_cnt == BIT_LAST) begin
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  // Capture happens one cycle after the last shift. A shift in that same
  // cycle starts the next word, but the nonblocking read still sees the
  // completed word. A clear in the capture cycle drops the word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rcv_data   <= '0;
      byte_ready <= 1'b0;
    end else begin
      byte_ready <= word_done && !clear;
      if (word_done && !clear) begin
        rcv_data <= sr_word;
      end
    end
  end

  assign stuff_err = (state == ERR);
  assign partial   = (bit_cnt != '0);

endmodule

// File: tb/tb_rx_deserializer.sv
// tb_rx_deserializer
// Directed bench for rx_deserializer. Instance A uses defaults (8 bits,
// LSB first, stuffing after 6 ones); instance B is 16 bits, MSB first.
// Expected words are queued as they are driven and popped on byte_ready.
module tb_rx_deserializer;

  logic clk = 1'b0;
  logic n_rst;

  logic       se_a, d_a, clr_a;
  logic [7:0] rd_a;
  logic       br_a, serr_a, part_a;

  logic        se_b, d_b, clr_b;
  logic [15:0] rd_b;
  logic        br_b, serr_b, part_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ones_a = 0;
  int last_b = -1;
  int count_b = 0;

  logic [7:0]  q_a[$];
  logic [15:0] q_b[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rx_deserializer u_dut_a (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (se_a),
    .d_orig       (d_a),
    .clear        (clr_a),
    .rcv_data     (rd_a),
    .byte_ready   (br_a),
    .stuff_err    (serr_a),
    .partial      (part_a)
  );

  rx_deserializer #(
    .DATA_WIDTH (16),
    .LSB_FIRST  (1'b0),
    .STUFF_LEN  (6)
  ) u_dut_b (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (se_b),
    .d_orig       (d_b),
    .clear        (clr_b),
    .rcv_data     (rd_b),
    .byte_ready   (br_b),
    .stuff_err    (serr_b),
    .partial      (part_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one enabled bit for exactly one cycle; consecutive calls give
  // back-to-back enables.
  task automatic applyStimulus(input int which, input logic b);
    if (which == 0) begin
      se_a = 1'b1;
      d_a  = b;
    end else begin
      se_b = 1'b1;
      d_b  = b;
    end
    @(negedge clk);
    se_a = 1'b0;
    se_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseClearA();
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    ones_a = 0;
  endtask

  // Sends a word LSB first, inserting a 0 after every run of six ones.
  task automatic sendWordA(input logic [7:0] w, input bit do_push);
    if (do_push) q_a.push_back(w);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, w[i]);
      ones_a = w[i] ? ones_a + 1 : 0;
      if (ones_a == 6) begin
        applyStimulus(0, 1'b0);
        ones_a = 0;
      end
    end
  endtask

  // Words for B never contain six-ones runs, so no stuffing is modelled.
  task automatic sendWordB(input logic [15:0] w);
    q_b.push_back(w);
    for (int i = 15; i >= 0; i--) applyStimulus(1, w[i]);
  endtask

  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (br_a === 1'b1) begin
        if (q_a.size() == 0) checkOutput("spurious_byte_ready_a", 32'(br_a), 32'd0);
        else checkOutput("word_a", 32'(rd_a), 32'(q_a.pop_front()));
      end
      if (br_b === 1'b1) begin
        if (q_b.size() == 0) begin
          checkOutput("spurious_byte_ready_b", 32'(br_b), 32'd0);
        end else begin
          checkOutput("word_b", 32'(rd_b), 32'(q_b.pop_front()));
          if (last_b >= 0) checkOutput("b_spacing", 32'(cyc - last_b), 32'd16);
          last_b = cyc;
        end
        count_b++;
      end
    end
  end

  initial begin
    n_rst = 1'b0;
    se_a = 1'b0; d_a = 1'b0; clr_a = 1'b0;
    se_b = 1'b0; d_b = 1'b0; clr_b = 1'b0;
    idle(2);
    checkOutput("rst_rcv_data_a", 32'(rd_a), 32'h0);
    checkOutput("rst_byte_ready_a", 32'(br_a), 32'h0);
    checkOutput("rst_stuff_err_a", 32'(serr_a), 32'h0);
    checkOutput("rst_partial_a", 32'(part_a), 32'h0);
    checkOutput("rst_rcv_data_b", 32'(rd_b), 32'h0);
    n_rst = 1'b1;
    idle(1);

    $display("[TB] basic word 0xA5");
    q_a.push_back(8'hA5);
    applyStimulus(0, 1'b1); applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b1); applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0); applyStimulus(0, 1'b1);
    applyStimulus(0, 1'b0); applyStimulus(0, 1'b1);
    checkOutput("a5_br_not_yet", 32'(br_a), 32'd0);
    checkOutput("a5_partial", 32'(part_a), 32'd0);
    idle(1);
    checkOutput("a5_br_pulse", 32'(br_a), 32'd1);
    checkOutput("a5_data", 32'(rd_a), 32'hA5);
    idle(1);
    checkOutput("a5_br_one_cycle", 32'(br_a), 32'd0);
    checkOutput("a5_data_held", 32'(rd_a), 32'hA5);

    $display("[TB] stuffed zero inside 0xFF");
    pulseClearA();
    q_a.push_back(8'hFF);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1);
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b1);
    applyStimulus(0, 1'b1);
    idle(2);
    checkOutput("ff_stuff_err", 32'(serr_a), 32'd0);
    checkOutput("ff_data", 32'(rd_a), 32'hFF);
    checkOutput("ff_one_byte_ready", 32'(q_a.size()), 32'd0);

    $display("[TB] stuffing violation");
    pulseClearA();
    for (int i = 0; i < 7; i++) applyStimulus(0, 1'b1);
    checkOutput("viol_stuff_err", 32'(serr_a), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1'(i % 2));
    idle(2);
    checkOutput("err_stuff_err_held", 32'(serr_a), 32'd1);
    checkOutput("err_partial_frozen", 32'(part_a), 32'd1);
    checkOutput("err_data_kept", 32'(rd_a), 32'hFF);
    pulseClearA();
    checkOutput("clr_stuff_err", 32'(serr_a), 32'd0);
    checkOutput("clr_partial", 32'(part_a), 32'd0);
    sendWordA(8'h3C, 1'b1);
    idle(2);
    checkOutput("after_err_data", 32'(rd_a), 32'h3C);

    $display("[TB] clear mid-word");
    applyStimulus(0, 1'b1); applyStimulus(0, 1'b0); applyStimulus(0, 1'b1);
    checkOutput("mid_partial", 32'(part_a), 32'd1);
    pulseClearA();
    checkOutput("mid_clr_partial", 32'(part_a), 32'd0);
    sendWordA(8'h3C, 1'b1);
    idle(2);
    checkOutput("mid_data", 32'(rd_a), 32'h3C);
    checkOutput("mid_queue", 32'(q_a.size()), 32'd0);

    $display("[TB] clear in capture cycle");
    sendWordA(8'h77, 1'b0);
    pulseClearA();
    idle(2);
    checkOutput("discard_data_kept", 32'(rd_a), 32'h3C);
    checkOutput("discard_partial", 32'(part_a), 32'd0);

    $display("[TB] back-to-back stuffed words");
    sendWordA(8'hFF, 1'b1);
    sendWordA(8'hFF, 1'b1);
    sendWordA(8'h81, 1'b1);
    idle(3);
    checkOutput("b2b_stuff_err", 32'(serr_a), 32'd0);
    checkOutput("b2b_data", 32'(rd_a), 32'h81);
    checkOutput("b2b_queue", 32'(q_a.size()), 32'd0);

    $display("[TB] 16-bit MSB-first instance");
    sendWordB(16'h1234);
    sendWordB(16'hBEEF);
    idle(3);
    checkOutput("b_data", 32'(rd_b), 32'hBEEF);
    checkOutput("b_count", 32'(count_b), 32'd2);
    checkOutput("b_stuff_err", 32'(serr_b), 32'd0);

    $display("[TB] reset mid-word");
    pulseClearA();
    applyStimulus(0, 1'b1); applyStimulus(0, 1'b1); applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b1); applyStimulus(0, 1'b0);
    n_rst = 1'b0;
    #1;
    checkOutput("mrst_data_a", 32'(rd_a), 32'h0);
    checkOutput("mrst_br_a", 32'(br_a), 32'h0);
    checkOutput("mrst_stuff_err_a", 32'(serr_a), 32'h0);
    checkOutput("mrst_partial_a", 32'(part_a), 32'h0);
    checkOutput("mrst_data_b", 32'(rd_b), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    ones_a = 0;
    idle(1);
    sendWordA(8'h96, 1'b1);
    idle(3);
    checkOutput("post_rst_data", 32'(rd_a), 32'h96);

    checkOutput("pending_a", 32'(q_a.size()), 32'd0);
    checkOutput("pending_b", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_deserializer.md
RX_DESERIALIZER -- requirements
Module: rx_deserializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per assembled word (legal 4..32).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1, meaning 1 = first received bit lands in bit 0, 0 = first received bit lands in bit DATA_WIDTH-1.
REQ-003 The block SHALL have parameter STUFF_LEN, default 6, meaning the count of consecutive ones after which one stuffed bit follows (legal 1..15).
REQ-004 The block SHALL have port clk, input, 1, system clock, rising-edge.
REQ-005 The block SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port shift_enable, input, 1, one-cycle strobe marking a valid decoded bit on d_orig.
REQ-007 The block SHALL have port d_orig, input, 1, NRZI-decoded serial bit, sampled only when shift_enable=1.
REQ-008 The block SHALL have port clear, input, 1, synchronous restart of word framing, asserted at SYNC and at EOP.
REQ-009 The block SHALL have port rcv_data, output, DATA_WIDTH, last complete word, held until the next complete word.
REQ-010 The block SHALL have port byte_ready, output, 1, one-cycle pulse coincident with each rcv_data update.
REQ-011 The block SHALL have port stuff_err, output, 1, level flag for a bit-stuffing violation, held until clear.
REQ-012 The block SHALL have port partial, output, 1, high while bits of an incomplete word are held (bit count != 0).

Function
REQ-013 The block SHALL implement states RUN and ERR; ERR is entered only on a stuffing violation and is left only via clear or reset.
REQ-014 In RUN, with shift_enable=1 and ones_cnt==STUFF_LEN, the bit SHALL be treated as stuffed: not shifted, bit_cnt unchanged, ones_cnt<=0.
REQ-015 A stuffed bit equal to 1 SHALL cause a transition to ERR and set stuff_err at the next edge.
REQ-016 In RUN, a non-stuffed enabled bit SHALL be shifted into the word (right shift with entry at MSB when LSB_FIRST=1; left shift with entry at LSB when LSB_FIRST=0).
REQ-017 For each shifted bit, ones_cnt SHALL become ones_cnt+1 if d_orig=1, else 0.
REQ-018 bit_cnt SHALL increment per shifted bit and wrap from DATA_WIDTH-1 to 0.
REQ-019 On the edge that shifts in bit DATA_WIDTH-1, a word-complete flag SHALL be set; on the following edge, rcv_data SHALL load the full word and byte_ready SHALL be 1 for exactly one cycle (latency: one cycle after the last shift).
REQ-020 A shift_enable arriving in the capture cycle SHALL shift normally into the next word without corrupting the captured word (back-to-back enables supported).
REQ-021 In ERR, shift_enable SHALL be ignored: no shifting, no counting, no byte_ready.
REQ-022 clear SHALL have priority over shift_enable and SHALL set bit_cnt=0, ones_cnt=0, stuff_err=0, and state=RUN; rcv_data SHALL be retained and any pending capture SHALL be discarded.
REQ-023 partial SHALL be derived combinationally as (bit_cnt != 0).
REQ-024 Counter widths SHALL be $clog2(DATA_WIDTH) for bit_cnt and $clog2(STUFF_LEN+1) for ones_cnt, with no overflow reachable.

Reset
REQ-025 On n_rst=0 the block SHALL asynchronously set: shift register all ones, rcv_data all zeros, byte_ready=0, stuff_err=0, bit_cnt=0, ones_cnt=0, state=RUN.
REQ-026 Reset asserted mid-word SHALL discard partial bits, with no byte_ready generated on reset release.

Structure
REQ-027 The state enum (RUN, ERR) and default constants (DATA_WIDTH=8, STUFF_LEN=6) SHALL reside in shared package usb_rx_pkg.
REQ-028 The shift path SHALL instantiate flex_stp_sr (NUM_BITS=DATA_WIDTH, SHIFT_MSB=!LSB_FIRST) with shift_enable gated by RUN and non-stuffed status; counters, FSM, and capture register SHALL live in rx_deserializer.

Verification
REQ-029 Defaults, bits 1,0,1,0,0,1,0,1 on 8 enables -> rcv_data=0xA5, byte_ready high one cycle, one cycle after the 8th enable, and partial=0.
REQ-030 Defaults, six 1s, stuffed 0, then two 1s (9 enables) -> rcv_data=0xFF, stuff_err=0, one byte_ready.
REQ-031 Defaults, seven consecutive 1s -> stuff_err=1 after the 7th enable; 10 further enables -> no byte_ready; clear -> stuff_err=0, and subsequent 0x3C is received correctly.
REQ-032 Three bits, then clear, then eight bits of 0x3C -> rcv_data=0x3C, with partial=1 after bit 3 and partial=0 after clear.
REQ-033 DATA_WIDTH=16, LSB_FIRST=0, 32 back-to-back enables carrying 0x1234 then 0xBEEF (no six-ones runs) -> two byte_ready pulses, 16 cycles apart, with the correct words.
REQ-034 n_rst pulsed after 5 bits -> all outputs take reset values; the next 8 bits yield a full word with no spurious byte_ready.
